// File: rtl/bypbuf_mode_if.sv
// bypbuf_mode_if
// Valid/ready stream bundle for bypbuf_mode. The upstream beat (i_vld, i_rdy,
// data_i) and the downstream beat (o_vld, o_rdy, data_o) travel together.
//
// Modports
//   master : the environment around the buffer (drives i_vld, data_i, o_rdy)
//   slave  : the buffer itself (drives i_rdy, o_vld, data_o)
//
// Parameters
//   DW : data width in bits
interface bypbuf_mode_if #(
    parameter int DW = 32
);
    logic          i_vld;
    logic          i_rdy;
    logic [DW-1:0] data_i;
    logic          o_vld;
    logic          o_rdy;
    logic [DW-1:0] data_o;

    modport master (
        output i_vld,
        output data_i,
        output o_rdy,
        input  i_rdy,
        input  o_vld,
        input  data_o
    );

    modport slave (
        input  i_vld,
        input  data_i,
        input  o_rdy,
        output i_rdy,
        output o_vld,
        output data_o
    );
endinterface

// File: rtl/bypbuf_mode.sv
// bypbuf_mode
// Bypass/pipe buffer for valid/ready streams. Cuts the ready path between
// two pipeline stages (i_rdy depends on registered occupancy only).
//   MODE 0 (bypass): a beat passes straight through while storage is empty
//                    and downstream is ready; otherwise it is queued.
//   MODE 1 (pipe)  : every beat is queued, so data/valid are also registered
//                    and there is one cycle of latency.
//
// Parameters
//   DP       : storage depth in entries (>= 1, any integer)
//   DW       : data width in bits
//   MODE     : 0 = bypass, 1 = pipe
//   AFULL_TH : afull asserts when level >= AFULL_TH (1..DP)
//   LW       : width of level, $clog2(DP+1) (derived, not overridable)
//
// Ports
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : bypbuf_mode_if.slave stream bundle (i_vld/i_rdy/data_i in,
//            o_vld/o_rdy/data_o out)
//   level  : entries currently held in storage, 0..DP
//   afull  : level >= AFULL_TH
//   flush  : synchronous clear, present only when BYPBUF_FLUSH_EN is defined
//
// Build option
//   BYPBUF_FLUSH_EN : adds the flush port. While flush is high the buffer
//                     accepts and presents nothing, and the next edge empties
//                     it. Without the macro storage clears only via rst_n.
module bypbuf_mode #(
    parameter int DP       = 4,
    parameter int DW       = 32,
    parameter int MODE     = 0,
    parameter int AFULL_TH = DP,
    localparam int LW      = $clog2(DP + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
`ifdef BYPBUF_FLUSH_EN
    input  logic          flush,
`endif
    bypbuf_mode_if.slave  bus,
    output logic [LW-1:0] level,
    output logic          afull
);

    localparam int PW = (DP > 1) ? $clog2(DP) : 1;

    logic [DW-1:0] mem_q [DP];
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [LW-1:0] level_q, level_d;

    logic flushAct;
    logic isEmpty;
    logic isFull;
    logic byp;
    logic oVldRaw;
    logic push;
    logic pop;

    // Pointers wrap explicitly because DP need not be a power of two.
    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(DP - 1)) ? '0 : p + PW'(1);
    endfunction

`ifdef BYPBUF_FLUSH_EN
    assign flushAct = flush;
`else
    assign flushAct = 1'b0;
`endif

    assign isEmpty = (level_q == '0);
    assign isFull  = (level_q == LW'(DP));

    // Ready comes from registered occupancy only, so o_rdy never reaches
    // i_rdy. A full buffer refuses even when a pop is happening this cycle.
    assign bus.i_rdy = ~isFull & ~flushAct;

    // Bypass mode lets an input beat skip storage when nothing is queued.
    // The stored head always wins the output mux, which keeps beats in order.
    // Pipe mode presents only stored data, giving a registered output.
    generate
        if (MODE == 0) begin : g_bypass
            assign byp        = bus.i_vld & bus.o_rdy & isEmpty;
            assign oVldRaw    = bus.i_vld | ~isEmpty;
            assign bus.data_o = isEmpty ? bus.data_i : mem_q[rdPtr_q];
        end else begin : g_pipe
            assign byp        = 1'b0;
            assign oVldRaw    = ~isEmpty;
            assign bus.data_o = mem_q[rdPtr_q];
        end
    endgenerate

    assign bus.o_vld = oVldRaw & ~flushAct;
    assign push      = bus.i_vld & bus.i_rdy & ~byp;
    assign pop       = bus.o_vld & bus.o_rdy & ~isEmpty;

    assign level = level_q;
    assign afull = (level_q >= LW'(AFULL_TH));

    // Next pointer/level state. Flush wins over push and pop; otherwise a
    // simultaneous push and pop leaves the level untouched.
    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        level_d = level_q;
        if (flushAct) begin
            rdPtr_d = '0;
            wrPtr_d = '0;
            level_d = '0;
        end else begin
            if (push) begin
                wrPtr_d = nextPtr(wrPtr_q);
            end
            if (pop) begin
                rdPtr_d = nextPtr(rdPtr_q);
            end
            case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // State and storage registers. Storage is cleared on reset as well so
    // that stale beats can never be seen on data_o after a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            level_q <= '0;
            for (int i = 0; i < DP; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            level_q <= level_d;
            if (push) begin
                mem_q[wrPtr_q] <= bus.data_i;
            end
        end
    end

endmodule
